// File: rtl/spi_controller_if.sv
// spi_controller_if: SPI receive pins plus command FIFO write port
interface spi_controller_if;
  logic       spi_clk;
  logic       spi_cs;
  logic       spi_data;
  logic [7:0] command_wrdata;
  logic       command_push;
  modport master (output spi_clk, spi_cs, spi_data, input command_wrdata, command_push);
  modport slave (input spi_clk, spi_cs, spi_data, output command_wrdata, command_push);
endinterface

// File: rtl/spi_controller.sv
// spi_controller: receive-only SPI slave, bytes handed to clk domain via toggle sync
module spi_controller #(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  spi_controller_if.slave  bus
);
  logic [2:0]             cnt_q, cnt_d;
  logic [6:0]             sh_q, sh_d;
  logic [7:0]             hold_q, data_q;
  logic                   tgl_q, edge_q, push_q, chg;
  logic [SYNC_STAGES-1:0] sync_q;
  always_comb begin
    cnt_d = cnt_q + 3'd1;
    sh_d  = {sh_q[5:0], bus.spi_data};
  end
  // deasserting chip select discards any partial byte
  always_ff @(posedge bus.spi_clk or posedge rst or negedge bus.spi_cs)
    if (rst) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else if (!bus.spi_cs) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
    end
  always_ff @(posedge bus.spi_clk or posedge rst)
    if (rst) begin
      hold_q <= '0;
      tgl_q  <= 1'b0;
    end else if (bus.spi_cs && cnt_q == 3'd7) begin
      hold_q <= {sh_q, bus.spi_data};
      tgl_q  <= ~tgl_q;
    end
  assign chg = sync_q[SYNC_STAGES-1] ^ edge_q;
  // hold_q is stable for 7 spi_clk periods after the toggle, so it is safe to sample here
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      push_q <= 1'b0;
      data_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tgl_q};
      edge_q <= sync_q[SYNC_STAGES-1];
      push_q <= chg;
      data_q <= chg ? hold_q : data_q;
    end
  assign bus.command_wrdata = data_q;
  assign bus.command_push   = push_q;
endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: directed frames, checks pushed bytes, push width and latency
module tb_spi_controller;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         rise_cyc = 0;
  logic       prev_push = 1'b0;
  logic [7:0] q[$];
  spi_controller_if bus();
  spi_controller #(.SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #14 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (prev_push) chk("push_width", {31'd0, bus.command_push}, 32'd0);
    if (bus.command_push && !rst) begin
      q.push_back(bus.command_wrdata);
      chk("latency_ok", {31'd0, (cyc - rise_cyc) >= 2 && (cyc - rise_cyc) <= 4}, 32'd1);
    end
    prev_push = bus.command_push;
  end
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      bus.spi_data = b[i];
      #24 bus.spi_clk = 1'b1;
      if (i == 0) rise_cyc = cyc;
      #24 bus.spi_clk = 1'b0;
    end
  endtask
  task automatic frame(input logic [39:0] bytes, input int n);
    logic [7:0] b;
    bus.spi_cs = 1'b1;
    for (int i = n - 1; i >= 0; i--) begin
      b = bytes[8*i +: 8];
      send_bits(b, 8);
    end
    #24 bus.spi_cs = 1'b0;
    #400;
  endtask
  task automatic expect_q(input string tag, input logic [39:0] exp, input int n);
    logic [7:0] got;
    chk({tag, "_count"}, q.size(), n);
    for (int i = n - 1; i >= 0; i--) begin
      got = (q.size() > 0) ? q.pop_front() : 8'hxx;
      chk(tag, {24'd0, got}, {24'd0, exp[8*i +: 8]});
    end
    q.delete();
  endtask
  initial begin
    bus.spi_clk = 1'b0;
    bus.spi_cs = 1'b0;
    bus.spi_data = 1'b0;
    #100;
    chk("rst_push", {31'd0, bus.command_push}, 32'd0);
    chk("rst_data", {24'd0, bus.command_wrdata}, 32'd0);
    rst = 1'b0;
    #50;
    frame(40'h01, 1);
    expect_q("t1", 40'h01, 1);
    frame(40'h2345, 2);
    expect_q("t2", 40'h2345, 2);
    frame(40'h6789ABCDEF, 5);
    expect_q("t3", 40'h6789ABCDEF, 5);
    bus.spi_cs = 1'b1;
    send_bits(8'hFF, 5);
    bus.spi_cs = 1'b0;
    #48;
    frame(40'h5A, 1);
    expect_q("t4", 40'h5A, 1);
    chk("t4_data", {24'd0, bus.command_wrdata}, 32'h5A);
    send_bits(8'hA5, 8);
    send_bits(8'h3C, 8);
    #400;
    expect_q("t5_cs_low", 40'h0, 0);
    bus.spi_cs = 1'b1;
    send_bits(8'hC3, 4);
    #10 rst = 1'b1;
    #1;
    chk("t5_rst_push", {31'd0, bus.command_push}, 32'd0);
    chk("t5_rst_data", {24'd0, bus.command_wrdata}, 32'd0);
    #60 rst = 1'b0;
    bus.spi_cs = 1'b0;
    #400;
    expect_q("t5_partial", 40'h0, 0);
    frame(40'h3C, 1);
    expect_q("t5", 40'h3C, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
